uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Program-load front end between the `uart` receiver and the fetch stage's instruction memory. While `flash` is high it parses a length-prefixed, checksummed byte stream from the UART and assembles little-endian 32-bit words. Each word is written to instruction memory at consecutive word addresses. It holds the CPU pipeline for the whole load and reports completion or error.

## Interface
- `IMEM_ADDR_WIDTH`, default 10: instruction-memory word-address width; capacity is 2^IMEM_ADDR_WIDTH words.
- `TIMEOUT_CYCLES`, default 2_000_000: maximum idle gap between bytes inside a frame before the frame is aborted.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  system clock (`clk_wiz_0` output).
  - `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `flash`  in  1  load-mode request, level, already synchronous to `clk`.
- `uart_valid`  in  1  one-cycle strobe: `uart_data` holds a new byte.
- `uart_data`  in  8  received byte.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_waddr`  out  IMEM_ADDR_WIDTH  word address of the current write.
- `imem_wdata`  out  32  assembled word.
- `cpu_hold`  out  1  stall/flush request to the pipeline; high in every state except IDLE.
- `load_done`  out  1  one-cycle pulse on a successful load.
- `load_error`  out  1  sticky error flag; cleared when the next frame starts.
- `word_count`  out  16  number of words written in the current or last frame.

## Operation
- Frame format:
  - Length bytes: `N[7:0]`, then `N[15:8]`.
  - Payload: 4·N bytes, little-endian per word (first byte goes to `[7:0]`).
  - Checksum: one byte equal to the XOR of all payload bytes.
- State machine states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE:
  - `flash`=1 → LEN_LO; on this transition clear `load_error`, `word_count`, the address, the byte index and the XOR accumulator.
- LEN_LO:
  - byte → latch N[7:0] → LEN_HI.
- LEN_HI:
  - byte → latch N[15:8].
  - N > 2^IMEM_ADDR_WIDTH → ERROR.
  - N = 0 → CHECK, where the expected checksum is 0x00.
  - otherwise → DATA.
- DATA:
  - Each byte is shifted into a 32-bit assembly register at byte index 0..3, and the XOR accumulator is updated.
  - On the 4th byte: write the word, increment address and `word_count`, reset the index to 0.
  - After word N is written → CHECK.
- CHECK:
  - byte equal to the accumulator → DONE, with `load_done` pulsing.
  - byte different → ERROR.
- DONE and ERROR:
  - remain while `flash`=1, and any further bytes are ignored.
  - `flash`=0 → IDLE.
- Abort conditions:
  - `flash` drops in LEN_LO, LEN_HI, DATA or CHECK → ERROR, with no further writes; the next cycle goes to IDLE because `flash`=0.
  - Timeout: in LEN_LO, LEN_HI, DATA or CHECK, a gap counter is reset by each `uart_valid` and on frame entry. Reaching TIMEOUT_CYCLES → ERROR.
- Entering ERROR sets `load_error`.
- Address wrap is impossible, because N is bounded at LEN_HI.
- Simultaneous events, in priority order: reset > `flash` drop > timeout > byte.
- Reset mid-operation:
  - All state is cleared and the partial word is discarded.
  - Words already written remain in memory.

## Timing
- Reset values:
  - state = IDLE.
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `cpu_hold`=0, `load_done`=0, `load_error`=0, `word_count`=0.
- All outputs are registered.
- `cpu_hold` rises one cycle after `flash` is first sampled high in IDLE.
- `cpu_hold` falls one cycle after `flash` is sampled low in DONE or ERROR.
- `imem_we` is high in the cycle after the clock edge that samples the 4th byte's `uart_valid`. `imem_waddr` and `imem_wdata` are valid in that same cycle.
- `load_done` is high for exactly the cycle after the edge that samples a matching checksum byte; the same edge enters DONE.
- Back-to-back `uart_valid` on consecutive cycles must be accepted without loss, giving one write per 4 bytes.

## Structure
- Shared package `riscv_pkg`:
  - `loader_state_t` enum.
  - frame-format constants: header length, checksum seed 0x00.
- One sub-module, `loader_timeout`:
  - gap counter with inputs `clear` and `enable`;
  - `expired` output when the count reaches TIMEOUT_CYCLES.
- The word assembler and the FSM stay in the top body.

## Test plan
- Nominal load, N=2, bytes 02 00 78 56 34 12 EF BE AD DE then checksum:
  - writes 0x12345678 @0 and 0xDEADBEEF @1;
  - `load_done` pulses once; `word_count`=2; `load_error`=0.
- Bad checksum (last byte flipped):
  - both words written; ERROR; `load_error`=1; no `load_done`; `cpu_hold` stays high until `flash`=0.
- N=0, frame 00 00 00:
  - no writes; `load_done` pulses; N=0 followed by checksum 01 → `load_error`=1.
- N = 2^IMEM_ADDR_WIDTH + 1:
  - ERROR immediately after LEN_HI; no writes.
- Timeout: stop after 2 payload bytes with TIMEOUT_CYCLES=16:
  - ERROR after 16 idle cycles; no write; the next frame clears `load_error` and loads correctly from address 0.
- Asynchronous reset asserted mid-DATA, and separately `flash` dropped mid-DATA:
  - all outputs return to their reset values immediately on reset;
  - on the `flash` drop: ERROR, then IDLE, and `cpu_hold`=0 two cycles later.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and frame-format constants for the UART program loader.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // Length prefix is two bytes, low byte first.
    localparam int unsigned HEADER_LEN    = 2;
    localparam logic [7:0]  CHECKSUM_SEED = 8'h00;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte gap counter: expired is asserted once TIMEOUT_CYCLES edges pass with no clear.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates one short of the limit so the error edge is the TIMEOUT_CYCLES-th idle edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt_q == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Parses a length-prefixed, XOR-checksummed UART byte stream into little-endian
// 32-bit words written to consecutive instruction-memory addresses.
module uart_program_loader
    import riscv_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT_CYCLES  = 2_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flash,
    input  logic                       uart_valid,
    input  logic [7:0]                 uart_data,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]                imem_wdata,
    output logic                       cpu_hold,
    output logic                       load_done,
    output logic                       load_error,
    output logic [15:0]                word_count
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << IMEM_ADDR_WIDTH;

    loader_state_t              state_q, state_d;
    logic [15:0]                len_q, len_d;
    logic [1:0]                 idx_q, idx_d;
    logic [23:0]                asm_q, asm_d;
    logic [7:0]                 xor_q, xor_d;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]                wc_q, wc_d;
    logic                       we_q, we_d;
    logic [IMEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       hold_q, hold_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [15:0]                len_n;
    logic                       in_frame;
    logic                       timer_clear;
    logic                       timer_expired;

    assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHECK);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear || uart_valid),
        .enable (in_frame),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        xor_d       = xor_q;
        addr_d      = addr_q;
        wc_d        = wc_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        timer_clear = 1'b0;
        len_n       = {uart_data, len_q[7:0]};

        case (state_q)
            ST_IDLE: begin
                if (flash) begin
                    state_d     = ST_LEN_LO;
                    err_d       = 1'b0;
                    wc_d        = '0;
                    addr_d      = '0;
                    idx_d       = '0;
                    xor_d       = CHECKSUM_SEED;
                    timer_clear = 1'b1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!flash) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Flash drop and timeout both outrank a byte arriving on the same edge.
                if (!flash || timer_expired) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else if (uart_valid) begin
                    case (state_q)
                        ST_LEN_LO: begin
                            len_d   = {len_q[15:8], uart_data};
                            state_d = ST_LEN_HI;
                        end
                        ST_LEN_HI: begin
                            len_d = len_n;
                            if ({1'b0, len_n} > MAX_WORDS) begin
                                state_d = ST_ERROR;
                                err_d   = 1'b1;
                            end else if (len_n == 16'd0) begin
                                state_d = ST_CHECK;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            xor_d = xor_q ^ uart_data;
                            asm_d = {uart_data, asm_q[23:8]};
                            idx_d = idx_q + 2'd1;
                            if (idx_q == 2'd3) begin
                                we_d    = 1'b1;
                                waddr_d = addr_q;
                                wdata_d = {uart_data, asm_q};
                                addr_d  = addr_q + IMEM_ADDR_WIDTH'(1);
                                wc_d    = wc_q + 16'd1;
                                idx_d   = '0;
                                if ((wc_q + 16'd1) == len_q) begin
                                    state_d = ST_CHECK;
                                end
                            end
                        end
                        ST_CHECK: begin
                            if (uart_data == xor_q) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_ERROR;
                                err_d   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        hold_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            xor_q   <= CHECKSUM_SEED;
            addr_q  <= '0;
            wc_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            xor_q   <= xor_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed self-checking bench for uart_program_loader (TIMEOUT_CYCLES reduced to 16).
module tb_uart_program_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          flash;
    logic          uart_valid;
    logic [7:0]    uart_data;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [15:0]   word_count;

    int            checks = 0;
    int            errors = 0;
    int            wr_n   = 0;
    int            done_n = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [31:0]   last_wdata = '0;

    uart_program_loader #(
        .IMEM_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flash     (flash),
        .uart_valid(uart_valid),
        .uart_data (uart_data),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) begin
            wr_n++;
            last_waddr = imem_waddr;
            last_wdata = imem_wdata;
        end
        if (load_done === 1'b1) done_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        uart_valid = 1'b1;
        uart_data  = b;
        @(negedge clk);
        uart_valid = 1'b0;
    endtask

    initial begin
        int          base;
        int          dbase;
        logic [7:0]  x;
        logic [7:0]  b;

        rst = 1'b0; flash = 1'b0; uart_valid = 1'b0; uart_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_we",    32'(imem_we),    32'h0);
        check("rst_waddr", 32'(imem_waddr), 32'h0);
        check("rst_wdata", imem_wdata,      32'h0);
        check("rst_hold",  32'(cpu_hold),   32'h0);
        check("rst_done",  32'(load_done),  32'h0);
        check("rst_err",   32'(load_error), 32'h0);
        check("rst_wc",    32'(word_count), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal N=2 load, checksum 0x2A
        flash = 1'b1;
        @(negedge clk);
        check("nom_hold_rise", 32'(cpu_hold), 32'h1);
        base = wr_n; dbase = done_n;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        check("nom_we_idle", 32'(imem_we), 32'h0);
        send_byte(8'h12);
        check("nom_we0",    32'(imem_we),    32'h1);
        check("nom_waddr0", 32'(imem_waddr), 32'h0);
        check("nom_wdata0", imem_wdata,      32'h12345678);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("nom_we1",    32'(imem_we),    32'h1);
        check("nom_waddr1", 32'(imem_waddr), 32'h1);
        check("nom_wdata1", imem_wdata,      32'hDEADBEEF);
        send_byte(8'h2A);
        check("nom_done_pulse", 32'(load_done),  32'h1);
        check("nom_wc",         32'(word_count), 32'd2);
        check("nom_err",        32'(load_error), 32'h0);
        @(negedge clk);
        check("nom_done_end",  32'(load_done),     32'h0);
        check("nom_hold_done", 32'(cpu_hold),      32'h1);
        check("nom_writes",    32'(wr_n - base),   32'd2);
        check("nom_done_cnt",  32'(done_n - dbase), 32'd1);
        flash = 1'b0;
        @(negedge clk);
        check("nom_hold_fall", 32'(cpu_hold), 32'h0);

        // Bad checksum
        flash = 1'b1;
        @(negedge clk);
        base = wr_n; dbase = done_n;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h2B);
        check("bad_err", 32'(load_error), 32'h1);
        repeat (3) @(negedge clk);
        send_byte(8'h55);
        check("bad_hold",     32'(cpu_hold),       32'h1);
        check("bad_writes",   32'(wr_n - base),    32'd2);
        check("bad_no_done",  32'(done_n - dbase), 32'd0);
        check("bad_wc",       32'(word_count),     32'd2);
        flash = 1'b0;
        @(negedge clk);
        check("bad_hold_fall",  32'(cpu_hold),   32'h0);
        check("bad_err_sticky", 32'(load_error), 32'h1);

        // N=0 good, then N=0 with wrong checksum
        flash = 1'b1;
        @(negedge clk);
        check("n0_err_clear", 32'(load_error), 32'h0);
        base = wr_n;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("n0_done",   32'(load_done),    32'h1);
        check("n0_wc",     32'(word_count),   32'd0);
        check("n0_writes", 32'(wr_n - base),  32'd0);
        flash = 1'b0;
        @(negedge clk);
        flash = 1'b1;
        @(negedge clk);
        dbase = done_n;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("n0_bad_err",  32'(load_error),    32'h1);
        check("n0_bad_done", 32'(done_n - dbase), 32'd0);
        flash = 1'b0;
        @(negedge clk);

        // N = 1025 rejected at LEN_HI
        flash = 1'b1;
        @(negedge clk);
        base = wr_n;
        send_byte(8'h01); send_byte(8'h04);
        check("big_err", 32'(load_error), 32'h1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("big_writes", 32'(wr_n - base), 32'd0);
        check("big_wc",     32'(word_count),  32'd0);
        flash = 1'b0;
        @(negedge clk);

        // N = 1024, largest legal frame; byte k of payload is k[7:0]
        flash = 1'b1;
        @(negedge clk);
        base = wr_n;
        send_byte(8'h00); send_byte(8'h04);
        x = 8'h00;
        for (int k = 0; k < 4096; k++) begin
            b = 8'(k);
            x = x ^ b;
            send_byte(b);
        end
        send_byte(x);
        check("max_done",   32'(load_done),   32'h1);
        check("max_err",    32'(load_error),  32'h0);
        check("max_wc",     32'(word_count),  32'd1024);
        check("max_writes", 32'(wr_n - base), 32'd1024);
        check("max_addr",   32'(last_waddr),  32'd1023);
        check("max_data",   last_wdata,       32'hFFFEFDFC);
        flash = 1'b0;
        @(negedge clk);

        // Timeout after two payload bytes, then a clean reload from address 0
        flash = 1'b1;
        @(negedge clk);
        base = wr_n;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        repeat (15) @(negedge clk);
        check("to_not_yet", 32'(load_error), 32'h0);
        @(negedge clk);
        check("to_err",    32'(load_error),  32'h1);
        check("to_writes", 32'(wr_n - base), 32'd0);
        flash = 1'b0;
        @(negedge clk);
        flash = 1'b1;
        @(negedge clk);
        check("to_next_clear", 32'(load_error), 32'h0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        check("to_next_waddr", 32'(imem_waddr), 32'h0);
        check("to_next_wdata", imem_wdata,      32'h01020304);
        send_byte(8'h04);
        check("to_next_done", 32'(load_done), 32'h1);
        flash = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-DATA, in the write cycle
        flash = 1'b1;
        @(negedge clk);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        check("ar_we_before", 32'(imem_we), 32'h1);
        #1 rst = 1'b0;
        #1;
        check("ar_we",    32'(imem_we),    32'h0);
        check("ar_wdata", imem_wdata,      32'h0);
        check("ar_hold",  32'(cpu_hold),   32'h0);
        check("ar_wc",    32'(word_count), 32'h0);
        flash = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ar_idle_hold", 32'(cpu_hold), 32'h0);

        // Flash dropped mid-DATA
        flash = 1'b1;
        @(negedge clk);
        base = wr_n;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        send_byte(8'h55);
        flash = 1'b0;
        @(negedge clk);
        check("fd_err",  32'(load_error), 32'h1);
        check("fd_hold", 32'(cpu_hold),   32'h1);
        @(negedge clk);
        check("fd_hold_fall", 32'(cpu_hold), 32'h0);
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        check("fd_writes", 32'(wr_n - base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
